bsg_nasti_master_req: RTL and testbench
=======================================

# bsg_nasti_master_req

Request-direction counterpart of the NASTI master response path: accepts AR, AW and W channel beats from a NASTI master, serializes them into tagged tunnel packets of type bsg_tun_dmx_t, and buffers them for the tunnel mux. Arbitration between read and write requests is round-robin. A write burst (AW plus len+1 W beats) is forwarded atomically, with no interleaved AR.

## Interface
- No parameters. All widths come from bsg_nasti_pkg and bsg_rocket_pkg (bsg_tun_dmx_width_p).
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- nasti_ar_valid_i  in  1  read address valid
- nasti_ar_data_i  in  bsg_nasti_a_pkt  id, addr, len[7:0], size[2:0], burst[1:0]
- nasti_ar_ready_o  out  1  AR accepted when valid & ready
- nasti_aw_valid_i  in  1  write address valid
- nasti_aw_data_i  in  bsg_nasti_a_pkt  same layout as AR
- nasti_aw_ready_o  out  1  AW accept
- nasti_w_valid_i  in  1  write data valid
- nasti_w_data_i  in  bsg_nasti_w_pkt  data, strb, last
- nasti_w_ready_o  out  1  W accept
- req_valid_o  out  1  tunnel packet available
- req_data_o  out  bsg_tun_dmx_t  packed bsg_nasti_sq_pkt
- req_yumi_i  in  1  consumer takes the packet (only when req_valid_o)
- err_o  out  1  sticky: W last flag disagreed with AW len

## Operation
- Packet bsg_nasti_sq_pkt has type[1:0] (0 = AR, 1 = AW, 2 = W) plus a payload. The payload is the a_pkt for AR/AW and the w_pkt for W, zero-padded to bsg_tun_dmx_width_p.
- FSM states:
  - IDLE: grant AR or AW. If both are valid, grant the one not granted last (last_grant register, reset to AW so AR wins first). If only one is valid, grant it. Readies are asserted only for the granted channel, and only when fifo_ready.
    - AR handshake: enqueue AR packet, stay in IDLE, last_grant <= AR.
    - AW handshake: enqueue AW packet, beat_cnt <= len, last_grant <= AW, go to WDATA.
  - WDATA: nasti_ar_ready_o = nasti_aw_ready_o = 0, nasti_w_ready_o = fifo_ready.
    - Each W handshake enqueues a W packet.
    - If beat_cnt == 0: go to IDLE. If last == 0, set err_o.
    - Else: beat_cnt decrements. If last == 1, set err_o and keep counting; termination is by count only.
- W beats presented in IDLE are not accepted (nasti_w_ready_o = 0). W-before-AW is not supported.
- beat_cnt is 8 bits. len = 255 gives 256 beats, with no wrap before terminating.
- Ready may depend on valid (grant is combinational from valids), as NASTI permits. Valid never depends on ready.
- err_o clears only on reset.

## Timing
- Reset values: all readies 0 during reset, req_valid_o = 0, err_o = 0, state = IDLE, beat_cnt = 0, last_grant = AW. The first cycle after reset, readies follow the rules above.
- Latency: a beat accepted in cycle N appears on req_valid_o in cycle N+1 (two-element FIFO, no bypass).
- Throughput: 1 packet/cycle sustained when req_yumi_i is held high.
- FIFO full: all readies 0. Grant and last_grant hold, so a stalled AR/AW keeps its grant until it is accepted.
- Accept and dequeue in the same cycle while full are not allowed. The two-fifo reports not-ready when full.
- Reset mid-burst: state returns to IDLE and the FIFO empties. Remaining W beats from the master are not accepted until a new AW arrives.

## Structure
- bsg_nasti_pkg holds:
  - bsg_nasti_sq_pkt
  - the type encoding constants (bsg_nasti_sq_ar_c = 0, bsg_nasti_sq_aw_c = 1, bsg_nasti_sq_w_c = 2)
  - a static check that bsg_nasti_sq_pkt width ≤ bsg_tun_dmx_width_p
- One sub-module: bsg_two_fifo (width bsg_tun_dmx_width_p) for output buffering. The FSM, arbiter and packer are local.

## Test plan
- Single AR (id = 3, addr = 0x1000, len = 0) → one packet next cycle, type 0, fields match. err_o = 0.
- AW len = 3 then W beats with last on beat 4 → 5 packets in order (AW, W×4), state back to IDLE. An AR held valid throughout is accepted only after the 4th W beat.
- AR and AW both valid continuously with len = 0 bursts → grants alternate, AR first after reset. Output type sequence is 0, 1, 2, 0, 1, 2.
- req_yumi_i held low for 10 cycles → exactly 2 packets accepted, then all readies 0. After yumi resumes, no packet is lost or duplicated.
- AW len = 1 with last = 1 on beat 1 → err_o = 1 from the next cycle. The burst still consumes 2 beats. err_o stays set until reset.
- Reset asserted after 2 of 4 W beats → req_valid_o = 0 the next cycle, state = IDLE, W not accepted until a new AW.

Source files
------------

// File: rtl/bsg_nasti_pkg.sv
// NASTI channel packets and the tunnel request packet format.
// Includes packers that place a channel beat into a tunnel word.
package bsg_nasti_pkg;

  typedef logic [bsg_rocket_pkg::bsg_tun_dmx_width_p-1:0] bsg_tun_dmx_t;

  typedef struct packed {
    logic [4:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } bsg_nasti_a_pkt;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } bsg_nasti_w_pkt;

  localparam int bsg_nasti_a_w_c = $bits(bsg_nasti_a_pkt);
  localparam int bsg_nasti_w_w_c = $bits(bsg_nasti_w_pkt);
  localparam int bsg_nasti_pay_w_c =
    (bsg_nasti_a_w_c > bsg_nasti_w_w_c) ?
    bsg_nasti_a_w_c : bsg_nasti_w_w_c;

  localparam logic [1:0] bsg_nasti_sq_ar_c = 2'd0;
  localparam logic [1:0] bsg_nasti_sq_aw_c = 2'd1;
  localparam logic [1:0] bsg_nasti_sq_w_c  = 2'd2;

  typedef struct packed {
    logic [1:0]                   typ;
    logic [bsg_nasti_pay_w_c-1:0] payload;
  } bsg_nasti_sq_pkt;

  localparam int bsg_nasti_sq_w_bits_c = $bits(bsg_nasti_sq_pkt);

  // Array size goes non-positive (elaboration error)
  // if the packet no longer fits the tunnel word.
  typedef logic bsg_nasti_fit_chk_t [
    bsg_rocket_pkg::bsg_tun_dmx_width_p
    - bsg_nasti_sq_w_bits_c + 1];

  typedef enum logic {
    BSG_NASTI_IDLE,
    BSG_NASTI_WDATA
  } bsg_nasti_req_state_e;

  function automatic bsg_tun_dmx_t bsg_nasti_pack_a(
    input logic [1:0]     typ,
    input bsg_nasti_a_pkt a
  );
    bsg_nasti_sq_pkt p;
    bsg_tun_dmx_t    r;
    p.typ = typ;
    p.payload = '0;
    p.payload[bsg_nasti_a_w_c-1:0] = a;
    r = '0;
    r[bsg_nasti_sq_w_bits_c-1:0] = p;
    return r;
  endfunction

  function automatic bsg_tun_dmx_t bsg_nasti_pack_w(
    input bsg_nasti_w_pkt w
  );
    bsg_nasti_sq_pkt p;
    bsg_tun_dmx_t    r;
    p.typ = bsg_nasti_sq_w_c;
    p.payload = '0;
    p.payload[bsg_nasti_w_w_c-1:0] = w;
    r = '0;
    r[bsg_nasti_sq_w_bits_c-1:0] = p;
    return r;
  endfunction

endpackage

// File: rtl/bsg_rocket_pkg.sv
// Rocket-side tunnel parameters shared by the NASTI tunnel endpoints.
// Holds the tunnel demux word width.
package bsg_rocket_pkg;

  localparam int bsg_tun_dmx_width_p = 80;

endpackage

// File: rtl/bsg_two_fifo.sv
// Two-entry FIFO, registered output, no bypass.
// Ports: ready_o/v_i enqueue side, v_o/data_o/yumi_i dequeue side.
module bsg_two_fifo #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  output logic               ready_o,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  logic [width_p-1:0] r_mem [2];
  logic               r_wptr;
  logic               r_rptr;
  logic [1:0]         r_cnt;
  logic               w_enq;
  logic               w_deq;

  assign ready_o = (r_cnt != 2'd2);
  assign v_o     = (r_cnt != 2'd0);
  assign data_o  = r_mem[r_rptr];
  assign w_enq   = v_i & ready_o;
  assign w_deq   = yumi_i & v_o;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_cnt  <= 2'd0;
    end else begin
      if (w_enq) r_wptr <= ~r_wptr;
      if (w_deq) r_rptr <= ~r_rptr;
      r_cnt <= r_cnt + {1'b0, w_enq}
                     - {1'b0, w_deq};
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_enq) r_mem[r_wptr] <= data_i;
  end

endmodule

// File: rtl/bsg_nasti_master_req.sv
// NASTI master request path: round-robin AR/AW grant, atomic W bursts,
// packed into tunnel words. Ports: AR/AW/W in, req_* out, sticky err_o.
module bsg_nasti_master_req
  import bsg_nasti_pkg::*;
(
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic           nasti_ar_valid_i,
  input  bsg_nasti_a_pkt nasti_ar_data_i,
  output logic           nasti_ar_ready_o,
  input  logic           nasti_aw_valid_i,
  input  bsg_nasti_a_pkt nasti_aw_data_i,
  output logic           nasti_aw_ready_o,
  input  logic           nasti_w_valid_i,
  input  bsg_nasti_w_pkt nasti_w_data_i,
  output logic           nasti_w_ready_o,
  output logic           req_valid_o,
  output bsg_tun_dmx_t   req_data_o,
  input  logic           req_yumi_i,
  output logic           err_o
);

  bsg_nasti_req_state_e r_state, w_state_n;
  logic [7:0]   r_beat_cnt, w_beat_cnt_n;
  logic         r_last_aw, w_last_aw_n;
  logic         r_err, w_err_n;
  logic         w_fifo_ready;
  logic         w_fifo_v;
  logic         w_enq;
  logic         w_open;
  logic         w_grant_aw;
  bsg_tun_dmx_t w_enq_data;

  // AW wins a tie only if AR went last.
  assign w_grant_aw = nasti_aw_valid_i
    & (~nasti_ar_valid_i | ~r_last_aw);
  assign w_open = w_fifo_ready & ~reset_i;

  always_comb begin
    w_state_n        = r_state;
    w_beat_cnt_n     = r_beat_cnt;
    w_last_aw_n      = r_last_aw;
    w_err_n          = r_err;
    w_enq            = 1'b0;
    w_enq_data       = '0;
    nasti_ar_ready_o = 1'b0;
    nasti_aw_ready_o = 1'b0;
    nasti_w_ready_o  = 1'b0;
    unique case (r_state)
      BSG_NASTI_IDLE: begin
        nasti_ar_ready_o = w_open
          & nasti_ar_valid_i & ~w_grant_aw;
        nasti_aw_ready_o = w_open & w_grant_aw;
        if (nasti_ar_ready_o) begin
          w_enq = 1'b1;
          w_enq_data = bsg_nasti_pack_a(
            bsg_nasti_sq_ar_c, nasti_ar_data_i);
          w_last_aw_n = 1'b0;
        end else if (nasti_aw_ready_o) begin
          w_enq = 1'b1;
          w_enq_data = bsg_nasti_pack_a(
            bsg_nasti_sq_aw_c, nasti_aw_data_i);
          w_last_aw_n = 1'b1;
          w_beat_cnt_n = nasti_aw_data_i.len;
          w_state_n = BSG_NASTI_WDATA;
        end
      end
      BSG_NASTI_WDATA: begin
        nasti_w_ready_o = w_open;
        if (w_open & nasti_w_valid_i) begin
          w_enq = 1'b1;
          w_enq_data = bsg_nasti_pack_w(nasti_w_data_i);
          // Burst ends on count; last only feeds err.
          if (r_beat_cnt == 8'd0) begin
            w_state_n = BSG_NASTI_IDLE;
            if (!nasti_w_data_i.last) w_err_n = 1'b1;
          end else begin
            w_beat_cnt_n = r_beat_cnt - 8'd1;
            if (nasti_w_data_i.last) w_err_n = 1'b1;
          end
        end
      end
      default: w_state_n = BSG_NASTI_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state    <= BSG_NASTI_IDLE;
      r_beat_cnt <= 8'd0;
      r_last_aw  <= 1'b1;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_beat_cnt <= w_beat_cnt_n;
      r_last_aw  <= w_last_aw_n;
      r_err      <= w_err_n;
    end
  end

  bsg_two_fifo #(
    .width_p(bsg_rocket_pkg::bsg_tun_dmx_width_p)
  ) u_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .ready_o(w_fifo_ready),
    .v_i    (w_enq),
    .data_i (w_enq_data),
    .v_o    (w_fifo_v),
    .data_o (req_data_o),
    .yumi_i (req_yumi_i & req_valid_o)
  );

  assign req_valid_o = w_fifo_v & ~reset_i;
  assign err_o       = r_err;

endmodule

// File: tb/tb_bsg_nasti_master_req.sv
// Directed bench for bsg_nasti_master_req: vector table plus
// hand sequences for stall, error and reset-mid-burst.
module tb_bsg_nasti_master_req;
  import bsg_nasti_pkg::*;

  logic           clk = 1'b0;
  logic           reset;
  logic           ar_v, aw_v, w_v;
  bsg_nasti_a_pkt ar_d, aw_d;
  bsg_nasti_w_pkt w_d;
  logic           ar_r, aw_r, w_r;
  logic           req_v, yumi, err;
  bsg_tun_dmx_t   req_d;

  int n_chk = 0;
  int n_pass = 0;

  bsg_nasti_master_req dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .nasti_ar_valid_i(ar_v),
    .nasti_ar_data_i (ar_d),
    .nasti_ar_ready_o(ar_r),
    .nasti_aw_valid_i(aw_v),
    .nasti_aw_data_i (aw_d),
    .nasti_aw_ready_o(aw_r),
    .nasti_w_valid_i (w_v),
    .nasti_w_data_i  (w_d),
    .nasti_w_ready_o (w_r),
    .req_valid_o     (req_v),
    .req_data_o      (req_d),
    .req_yumi_i      (yumi),
    .err_o           (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [5:0] in;
    logic [7:0] len;
    logic [3:0] e;
    logic [1:0] ty;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string nm,
                     input logic [79:0] act,
                     input logic [79:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bsg_nasti_a_pkt mk_a(
    input logic [4:0] id, input logic [31:0] addr,
    input logic [7:0] len);
    bsg_nasti_a_pkt a;
    a.id = id; a.addr = addr; a.len = len;
    a.size = 3'd3; a.burst = 2'd1;
    return a;
  endfunction

  function automatic bsg_nasti_w_pkt mk_w(input logic last);
    bsg_nasti_w_pkt w;
    w.data = 64'hDEAD_BEEF_0123_4567;
    w.strb = 8'hFF; w.last = last;
    return w;
  endfunction

  function automatic bsg_nasti_sq_pkt sq_of(input bsg_tun_dmx_t d);
    bsg_nasti_sq_pkt p;
    p = d[$bits(bsg_nasti_sq_pkt)-1:0];
    return p;
  endfunction

  function automatic bsg_nasti_a_pkt a_of(input bsg_tun_dmx_t d);
    bsg_nasti_sq_pkt p;
    p = sq_of(d);
    return p.payload[$bits(bsg_nasti_a_pkt)-1:0];
  endfunction

  function automatic bsg_nasti_w_pkt w_of(input bsg_tun_dmx_t d);
    bsg_nasti_sq_pkt p;
    p = sq_of(d);
    return p.payload[$bits(bsg_nasti_w_pkt)-1:0];
  endfunction

  initial begin
    bsg_nasti_sq_pkt ep;
    bsg_tun_dmx_t    ed;
    int acc, k, hs;
    logic [31:0] got[$];

    // in = {rst, ar, aw, w, last, yumi}; e = {ar, aw, w, req_v}
    tbl[0]  = '{"aw_tie",  6'b011000, 8'd3, 4'b0100, 2'd0};
    tbl[1]  = '{"wb1",     6'b010101, 8'd3, 4'b0011, 2'd1};
    tbl[2]  = '{"wb2",     6'b010101, 8'd3, 4'b0011, 2'd2};
    tbl[3]  = '{"wb3",     6'b010101, 8'd3, 4'b0011, 2'd2};
    tbl[4]  = '{"wb4",     6'b010111, 8'd3, 4'b0011, 2'd2};
    tbl[5]  = '{"ar_aft",  6'b010001, 8'd3, 4'b1001, 2'd2};
    tbl[6]  = '{"drain",   6'b000001, 8'd3, 4'b0001, 2'd0};
    tbl[7]  = '{"rst",     6'b111110, 8'd0, 4'b0000, 2'd0};
    tbl[8]  = '{"rr_ar1",  6'b011110, 8'd0, 4'b1000, 2'd0};
    tbl[9]  = '{"rr_aw1",  6'b011111, 8'd0, 4'b0101, 2'd0};
    tbl[10] = '{"rr_w1",   6'b011111, 8'd0, 4'b0011, 2'd1};
    tbl[11] = '{"rr_ar2",  6'b011111, 8'd0, 4'b1001, 2'd2};
    tbl[12] = '{"rr_aw2",  6'b011111, 8'd0, 4'b0101, 2'd0};
    tbl[13] = '{"rr_w2",   6'b011111, 8'd0, 4'b0011, 2'd1};
    tbl[14] = '{"rr_end",  6'b000001, 8'd0, 4'b0001, 2'd2};
    tbl[15] = '{"idle",    6'b000000, 8'd0, 4'b0000, 2'd0};

    reset = 1'b1; ar_v = 1'b1; aw_v = 1'b1; w_v = 1'b1;
    yumi = 1'b0;
    ar_d = mk_a(5'd3, 32'h1000, 8'd0);
    aw_d = mk_a(5'd5, 32'h2000, 8'd0);
    w_d  = mk_w(1'b0);
    tick();
    @(negedge clk);
    chk("rst_ar_rdy", ar_r, 0);
    chk("rst_aw_rdy", aw_r, 0);
    chk("rst_w_rdy", w_r, 0);
    chk("rst_req_v", req_v, 0);
    chk("rst_err", err, 0);
    tick();
    reset = 1'b0; ar_v = 1'b0; aw_v = 1'b0; w_v = 1'b0;
    tick();

    // single AR
    ar_v = 1'b1;
    @(negedge clk);
    chk("ar1_rdy", ar_r, 1);
    chk("ar1_aw_rdy", aw_r, 0);
    chk("ar1_req_v", req_v, 0);
    tick();
    ar_v = 1'b0; yumi = 1'b1;
    ep.typ = 2'd0; ep.payload = '0;
    ep.payload[$bits(bsg_nasti_a_pkt)-1:0] = ar_d;
    ed = '0;
    ed[$bits(bsg_nasti_sq_pkt)-1:0] = ep;
    @(negedge clk);
    chk("ar1_out_v", req_v, 1);
    chk("ar1_type", sq_of(req_d).typ, 0);
    chk("ar1_id", a_of(req_d).id, 3);
    chk("ar1_addr", a_of(req_d).addr, 32'h1000);
    chk("ar1_word", req_d, ed);
    chk("ar1_err", err, 0);
    tick();
    yumi = 1'b0;

    for (int i = 0; i < 16; i++) begin
      reset = tbl[i].in[5];
      ar_v  = tbl[i].in[4];
      aw_v  = tbl[i].in[3];
      w_v   = tbl[i].in[2];
      w_d   = mk_w(tbl[i].in[1]);
      yumi  = tbl[i].in[0];
      aw_d  = mk_a(5'd5, 32'h2000, tbl[i].len);
      @(negedge clk);
      chk({tbl[i].nm, "_ar"}, ar_r, tbl[i].e[3]);
      chk({tbl[i].nm, "_aw"}, aw_r, tbl[i].e[2]);
      chk({tbl[i].nm, "_w"}, w_r, tbl[i].e[1]);
      chk({tbl[i].nm, "_v"}, req_v, tbl[i].e[0]);
      if (tbl[i].e[0])
        chk({tbl[i].nm, "_ty"}, sq_of(req_d).typ, tbl[i].ty);
      chk({tbl[i].nm, "_err"}, err, 0);
      tick();
    end

    // yumi held low: two entries then all readies drop
    ar_v = 1'b1; yumi = 1'b0; acc = 0; k = 0;
    for (int i = 0; i < 10; i++) begin
      ar_d = mk_a(5'd1, k, 8'd0);
      @(negedge clk);
      hs = int'(ar_r);
      acc += hs;
      if (i == 9) begin
        chk("stall_ar_rdy", ar_r, 0);
        chk("stall_req_v", req_v, 1);
      end
      tick();
      k += hs;
    end
    chk("stall_acc", acc, 2);
    for (int i = 0; i < 40 && (k < 4 || req_v); i++) begin
      ar_v = (k < 4);
      ar_d = mk_a(5'd1, k, 8'd0);
      yumi = req_v;
      @(negedge clk);
      hs = int'(ar_v & ar_r);
      if (yumi) got.push_back(a_of(req_d).addr);
      tick();
      k += hs;
    end
    ar_v = 1'b0; yumi = 1'b0;
    chk("stall_cnt", got.size(), 4);
    for (int i = 0; i < got.size(); i++)
      chk($sformatf("stall_ord%0d", i), got[i], i);

    // last asserted early on a 2-beat burst
    aw_v = 1'b1; aw_d = mk_a(5'd2, 32'h3000, 8'd1);
    @(negedge clk);
    chk("err_aw_rdy", aw_r, 1);
    tick();
    aw_v = 1'b0; w_v = 1'b1; w_d = mk_w(1'b1); yumi = req_v;
    @(negedge clk);
    chk("err_w1_rdy", w_r, 1);
    chk("err_pre", err, 0);
    tick();
    w_d = mk_w(1'b0); yumi = req_v;
    @(negedge clk);
    chk("err_set", err, 1);
    chk("err_w2_rdy", w_r, 1);
    chk("err_w1_ty", sq_of(req_d).typ, 2);
    chk("err_w1_dat", w_of(req_d).data, 64'hDEAD_BEEF_0123_4567);
    chk("err_w1_last", w_of(req_d).last, 1);
    tick();
    yumi = req_v;
    @(negedge clk);
    chk("err_w3_rdy", w_r, 0);
    tick();
    w_v = 1'b0;
    for (int i = 0; i < 5; i++) begin
      yumi = req_v;
      tick();
    end
    yumi = 1'b0;
    @(negedge clk);
    chk("err_sticky", err, 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("err_clr", err, 0);
    tick();

    // reset after two of four W beats
    aw_v = 1'b1; aw_d = mk_a(5'd4, 32'h4000, 8'd3);
    @(negedge clk);
    chk("mid_aw_rdy", aw_r, 1);
    tick();
    aw_v = 1'b0; w_v = 1'b1; w_d = mk_w(1'b0);
    for (int i = 0; i < 2; i++) begin
      yumi = req_v;
      @(negedge clk);
      chk($sformatf("mid_w%0d_rdy", i), w_r, 1);
      tick();
    end
    reset = 1'b1; yumi = 1'b0;
    @(negedge clk);
    chk("mid_rst_w", w_r, 0);
    chk("mid_rst_v", req_v, 0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_post_v", req_v, 0);
    chk("mid_post_w", w_r, 0);
    tick();
    @(negedge clk);
    chk("mid_post_w2", w_r, 0);
    tick();
    aw_v = 1'b1; w_v = 1'b1;
    @(negedge clk);
    chk("mid_new_aw", aw_r, 1);
    chk("mid_new_w0", w_r, 0);
    tick();
    aw_v = 1'b0; yumi = req_v;
    @(negedge clk);
    chk("mid_new_w", w_r, 1);
    chk("mid_new_ty", sq_of(req_d).typ, 1);
    tick();
    w_v = 1'b0; yumi = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
